// File: rtl/atom_dmem_pkg.sv
// ---------------------------------------------------------------------------
// atom_dmem_pkg
//   Shared definitions for the AtomRV data-memory responder: RV funct3 access
//   width codes, MMIO word selectors, read-buffer FSM states, the source of a
//   fetched word, and the load lane-extraction helper.
// ---------------------------------------------------------------------------
package atom_dmem_pkg;

  // RV funct3 load/store width codes
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // MMIO word selectors (addr[3:2])
  localparam logic [1:0] MMIO_TICK_LO = 2'd0;
  localparam logic [1:0] MMIO_TICK_HI = 2'd1;
  localparam logic [1:0] MMIO_STATUS  = 2'd2;
  localparam logic [1:0] MMIO_RSVD    = 2'd3;

  // Read-buffer FSM
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_FILL = 2'b01,
    ST_HOLD = 2'b10
  } state_e;

  // Where the word being filled comes from
  typedef enum logic [1:0] {
    SRC_NONE = 2'b00,
    SRC_RAM  = 2'b01,
    SRC_MMIO = 2'b10
  } src_e;

  // Pick the addressed lane out of a word and extend it for the core.
  // Half-word lanes use lane[1] only, so a misaligned load reads the
  // aligned-down half.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [2:0]  width);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'h00;
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (width)
      F3_B:    res = {{24{b[7]}}, b};
      F3_BU:   res = {24'h000000, b};
      F3_H:    res = {{16{h[15]}}, h};
      F3_HU:   res = {16'h0000, h};
      F3_W:    res = word;
      default: res = 32'h0000_0000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/atom_bram_be.sv
// ---------------------------------------------------------------------------
// atom_bram_be
//   32-bit x 2**AW synchronous RAM with four byte-write enables and a
//   registered read of the same address. Contents are never cleared; only
//   the read register is reset.
// Ports
//   i_clk    clock
//   i_rst    synchronous active-high reset (read register only)
//   i_addr   word address, shared by read and write
//   i_be     byte-write enables, bit n writes bits [8n+7:8n]
//   i_wdata  write data, already replicated onto its lanes
//   o_rdata  word read at i_addr on the previous clock
// ---------------------------------------------------------------------------
module atom_bram_be #(
  parameter int AW = 12
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [AW-1:0] i_addr,
  input  logic [3:0]    i_be,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [0:(2**AW)-1];
  logic [31:0] r_rdata;

  // Byte-lane writes into the array
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < 4; i++) begin
      if (i_be[i]) begin
        r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
  end

  // Registered read port
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdata <= 32'h0000_0000;
    end else begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/atom_dmem_responder.sv
// ---------------------------------------------------------------------------
// atom_dmem_responder
//   Target side of the AtomRV data-memory port. Decodes each access into
//   RAM, MMIO or unmapped space. Loads are served from a one-word read
//   buffer; fetching a new word costs one hlt_o cycle because the RAM read
//   is registered. MMIO holds a 64-bit free-running tick counter (read LO
//   first: it snapshots HI into a shadow) and a sticky misaligned-store flag.
// Ports
//   clk_i                clock
//   rst_i                synchronous active-high reset
//   dmem_addr_i          byte address from the core
//   dmem_data_i          store data, valid lanes start at bit 0
//   dmem_access_width_i  RV funct3 width
//   dmem_we_i            store strobe, commits in the cycle it is high
//   dmem_data_o          extended load data
//   hlt_o                stall request to the core
//   misaligned_o         sticky misaligned-store flag
// ---------------------------------------------------------------------------
module atom_dmem_responder
  import atom_dmem_pkg::*;
#(
  parameter int          MEM_AW    = 12,
  parameter logic [31:0] RAM_BASE  = 32'h0001_0000,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] dmem_addr_i,
  input  logic [31:0] dmem_data_i,
  input  logic [2:0]  dmem_access_width_i,
  input  logic        dmem_we_i,
  output logic [31:0] dmem_data_o,
  output logic        hlt_o,
  output logic        misaligned_o
);

  logic        w_ram_hit;
  logic        w_mmio_hit;
  logic [1:0]  w_lane;
  logic [1:0]  w_mmio_sel;
  logic [29:0] w_tag;
  logic [3:0]  w_strobe;
  logic [31:0] w_wdata;
  logic        w_misalign;
  logic        w_store_ok;
  logic        w_store_bad;
  logic        w_mmio_we;
  logic [3:0]  w_ram_be;
  logic        w_tag_hit;
  logic        w_fetch;
  logic        w_merge;
  logic [31:0] w_ram_rdata;
  logic [31:0] w_mmio_rdata;
  logic [31:0] w_fill_word;
  logic [31:0] w_word_view;
  logic [31:0] w_word_next;
  logic [63:0] w_cnt_inc;
  logic [63:0] w_cnt_next;

  state_e      r_state;
  src_e        r_src;
  logic [31:0] r_word;
  logic [29:0] r_tag;
  logic [31:0] r_mmio_data;
  logic [63:0] r_cnt;
  logic [31:0] r_hi_shadow;
  logic        r_misaligned;

  assign w_ram_hit  = (dmem_addr_i[31:MEM_AW+2] == RAM_BASE[31:MEM_AW+2]);
  assign w_mmio_hit = (dmem_addr_i[31:4] == MMIO_BASE[31:4]);
  assign w_lane     = dmem_addr_i[1:0];
  assign w_mmio_sel = dmem_addr_i[3:2];
  assign w_tag      = dmem_addr_i[31:2];

  // Store lane strobes, replicated data and alignment check
  always_comb begin
    w_strobe   = 4'b0000;
    w_wdata    = dmem_data_i;
    w_misalign = 1'b0;
    case (dmem_access_width_i[1:0])
      2'b00: begin
        w_strobe = 4'b0001 << w_lane;
        w_wdata  = {4{dmem_data_i[7:0]}};
      end
      2'b01: begin
        w_strobe   = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wdata    = {2{dmem_data_i[15:0]}};
        w_misalign = w_lane[0];
      end
      2'b10: begin
        w_strobe   = 4'b1111;
        w_misalign = (w_lane != 2'b00);
      end
      default: begin
        w_strobe = 4'b0000;
      end
    endcase
  end

  assign w_store_ok  = dmem_we_i & ~rst_i & ~w_misalign & (w_strobe != 4'b0000);
  assign w_store_bad = dmem_we_i & ~rst_i & w_misalign;
  assign w_ram_be    = (w_store_ok & w_ram_hit) ? w_strobe : 4'b0000;
  assign w_mmio_we   = w_store_ok & w_mmio_hit;

  // A load needs a new word when nothing is buffered or the buffered tag differs
  assign w_tag_hit = (w_tag == r_tag);
  assign w_fetch   = ~rst_i & ~dmem_we_i &
                     ((r_state == ST_IDLE) | ((r_state == ST_HOLD) & ~w_tag_hit));
  // Stores to the buffered RAM word must also patch the buffer copy
  assign w_merge   = w_store_ok & w_ram_hit & w_tag_hit &
                     ((r_state == ST_FILL) | (r_state == ST_HOLD));

  atom_bram_be #(
    .AW(MEM_AW)
  ) u_ram (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_addr  (dmem_addr_i[MEM_AW+1:2]),
    .i_be    (w_ram_be),
    .i_wdata (w_wdata),
    .o_rdata (w_ram_rdata)
  );

  // Buffered-word view: during FILL the word arrives straight from its source
  always_comb begin
    case (r_src)
      SRC_RAM:  w_fill_word = w_ram_rdata;
      SRC_MMIO: w_fill_word = r_mmio_data;
      default:  w_fill_word = 32'h0000_0000;
    endcase
    if (r_state == ST_FILL) begin
      w_word_view = w_fill_word;
    end else begin
      w_word_view = r_word;
    end
    w_word_next = w_word_view;
    for (int i = 0; i < 4; i++) begin
      if (w_merge && w_strobe[i]) begin
        w_word_next[8*i +: 8] = w_wdata[8*i +: 8];
      end else begin
        w_word_next[8*i +: 8] = w_word_view[8*i +: 8];
      end
    end
  end

  // MMIO read mux, sampled in the fetch cycle
  always_comb begin
    case (w_mmio_sel)
      MMIO_TICK_LO: w_mmio_rdata = r_cnt[31:0];
      MMIO_TICK_HI: w_mmio_rdata = r_hi_shadow;
      MMIO_STATUS:  w_mmio_rdata = {31'h0000_0000, r_misaligned};
      MMIO_RSVD:    w_mmio_rdata = 32'h0000_0000;
      default:      w_mmio_rdata = 32'h0000_0000;
    endcase
  end

  // A write replaces only its own half; the other half keeps counting
  assign w_cnt_inc         = r_cnt + 64'd1;
  assign w_cnt_next[31:0]  = (w_mmio_we && (w_mmio_sel == MMIO_TICK_LO)) ? dmem_data_i : w_cnt_inc[31:0];
  assign w_cnt_next[63:32] = (w_mmio_we && (w_mmio_sel == MMIO_TICK_HI)) ? dmem_data_i : w_cnt_inc[63:32];

  // Read-buffer FSM: IDLE/HOLD fetch on a load miss, FILL delivers the word
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_src       <= SRC_NONE;
      r_word      <= 32'h0000_0000;
      r_tag       <= 30'h0000_0000;
      r_mmio_data <= 32'h0000_0000;
    end else begin
      case (r_state)
        ST_FILL: begin
          r_word  <= w_word_next;
          // MMIO words can change every cycle, so they are never held
          r_state <= (r_src == SRC_MMIO) ? ST_IDLE : ST_HOLD;
        end
        ST_IDLE, ST_HOLD: begin
          if (w_fetch) begin
            r_tag       <= w_tag;
            r_mmio_data <= w_mmio_rdata;
            r_src       <= w_ram_hit ? SRC_RAM : (w_mmio_hit ? SRC_MMIO : SRC_NONE);
            r_state     <= ST_FILL;
          end else begin
            r_word <= w_word_next;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Tick counter, HI shadow snapshot on a LO fetch, sticky misaligned flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt        <= 64'd0;
      r_hi_shadow  <= 32'h0000_0000;
      r_misaligned <= 1'b0;
    end else begin
      r_cnt <= w_cnt_next;
      if (w_fetch && w_mmio_hit && (w_mmio_sel == MMIO_TICK_LO)) begin
        r_hi_shadow <= r_cnt[63:32];
      end
      if (w_store_bad) begin
        r_misaligned <= 1'b1;
      end else if (w_mmio_we && (w_mmio_sel == MMIO_STATUS)) begin
        r_misaligned <= 1'b0;
      end
    end
  end

  assign hlt_o        = w_fetch;
  assign dmem_data_o  = rst_i ? 32'h0000_0000 : load_extract(w_word_view, w_lane, dmem_access_width_i);
  assign misaligned_o = r_misaligned;

endmodule

// File: tb/tb_atom_dmem_responder.sv
module tb_atom_dmem_responder;

  localparam logic [31:0] RAM_B  = 32'h0001_0000;
  localparam logic [31:0] MMIO_B = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] din;
  logic [2:0]  wd;
  logic        we;
  logic [31:0] dout;
  logic        hlt;
  logic        mis;

  always #5 clk = ~clk;

  atom_dmem_responder dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .dmem_addr_i         (addr),
    .dmem_data_i         (din),
    .dmem_access_width_i (wd),
    .dmem_we_i           (we),
    .dmem_data_o         (dout),
    .hlt_o               (hlt),
    .misaligned_o        (mis)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [7:0]  m_ram [0:63];
  logic [63:0] m_cnt;
  logic        m_flag;
  logic [31:0] m_shadow;
  logic        m_held_v;
  logic [29:0] m_held_tag;

  function automatic bit is_ram(input logic [31:0] a);
    return a[31:14] == RAM_B[31:14];
  endfunction

  function automatic bit is_mmio(input logic [31:0] a);
    return a[31:4] == MMIO_B[31:4];
  endfunction

  function automatic logic [31:0] m_word(input logic [31:0] a);
    logic [5:0] b;
    b = {a[5:2], 2'b00};
    return {m_ram[b + 6'd3], m_ram[b + 6'd2], m_ram[b + 6'd1], m_ram[b]};
  endfunction

  function automatic logic [31:0] ext(input logic [31:0] word, input logic [1:0] a, input logic [2:0] w);
    logic [31:0] sh;
    case (w)
      3'd0: begin sh = word >> (8 * a);    return {{24{sh[7]}}, sh[7:0]}; end
      3'd4: begin sh = word >> (8 * a);    return {24'd0, sh[7:0]}; end
      3'd1: begin sh = word >> (16 * a[1]); return {{16{sh[15]}}, sh[15:0]}; end
      3'd5: begin sh = word >> (16 * a[1]); return {16'd0, sh[15:0]}; end
      3'd2: return word;
      default: return 32'd0;
    endcase
  endfunction

  // model: every committed store and the counter, applied at the clock edge
  always @(posedge clk) begin : model_b
    logic [63:0] nxt;
    logic        bad;
    if (rst) begin
      m_cnt  = 64'd0;
      m_flag = 1'b0;
    end else begin
      nxt = m_cnt + 64'd1;
      if (we) begin
        bad = (wd[1:0] == 2'b01 && addr[0]) || (wd[1:0] == 2'b10 && addr[1:0] != 2'b00);
        if (bad) begin
          m_flag = 1'b1;
        end else if (wd[1:0] != 2'b11) begin
          if (is_ram(addr)) begin
            if (wd[1:0] == 2'b00) m_ram[addr[5:0]] = din[7:0];
            else if (wd[1:0] == 2'b01) begin
              m_ram[{addr[5:1], 1'b0}] = din[7:0];
              m_ram[{addr[5:1], 1'b1}] = din[15:8];
            end else begin
              for (int k = 0; k < 4; k++) m_ram[{addr[5:2], 2'(k)}] = din[8*k +: 8];
            end
          end else if (is_mmio(addr)) begin
            if (addr[3:2] == 2'd0) nxt[31:0] = din;
            else if (addr[3:2] == 2'd1) nxt[63:32] = din;
            else if (addr[3:2] == 2'd2) m_flag = 1'b0;
          end
        end
      end
      m_cnt = nxt;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // every task starts 1 time unit after a rising edge and ends at the same point
  task automatic do_load(input logic [31:0] a, input logic [2:0] w, input string tag,
                         output logic [31:0] got);
    logic        stall;
    logic [31:0] word;
    stall = !(m_held_v && m_held_tag == a[31:2]);
    word  = 32'd0;
    addr = a; wd = w; we = 1'b0; din = $urandom;
    @(negedge clk);
    chk({tag, " hlt"}, {31'd0, hlt}, {31'd0, stall});
    if (stall) begin
      if (is_mmio(a)) begin
        case (a[3:2])
          2'd0: begin word = m_cnt[31:0]; m_shadow = m_cnt[63:32]; end
          2'd1: word = m_shadow;
          2'd2: word = {31'd0, m_flag};
          default: word = 32'd0;
        endcase
      end
      @(posedge clk); #1;
      @(negedge clk);
      chk({tag, " hlt_fill"}, {31'd0, hlt}, 32'd0);
    end
    if (!is_mmio(a)) word = is_ram(a) ? m_word(a) : 32'd0;
    chk({tag, " data"}, dout, ext(word, a[1:0], w));
    chk({tag, " mis"}, {31'd0, mis}, {31'd0, m_flag});
    got = dout;
    @(posedge clk); #1;
    m_held_v   = !is_mmio(a);
    m_held_tag = a[31:2];
  endtask

  task automatic do_store(input logic [31:0] a, input logic [2:0] w, input logic [31:0] d,
                          input string tag);
    addr = a; wd = w; we = 1'b1; din = d;
    @(negedge clk);
    chk({tag, " hlt"}, {31'd0, hlt}, 32'd0);
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] last_a;
    logic [31:0] a;
    logic [2:0]  ldw [0:7];
    ldw = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd2, 3'd3, 3'd6};
    rst = 1'b1; addr = 32'd0; din = 32'd0; wd = 3'd2; we = 1'b0;
    m_shadow = 32'd0; m_held_v = 1'b0; m_held_tag = 30'd0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst hlt", {31'd0, hlt}, 32'd0);
    chk("rst data", dout, 32'd0);
    chk("rst mis", {31'd0, mis}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: store then word load with one stall
    do_store(32'h0001_0000, 3'd2, 32'hDEAD_BEEF, "t1 sw");
    do_load(32'h0001_0000, 3'd2, "t1 lw", got);
    chk("t1 lw lit", got, 32'hDEAD_BEEF);
    // 2: same word, no stall
    do_load(32'h0001_0003, 3'd0, "t2 lb", got);
    chk("t2 lb lit", got, 32'hFFFF_FFDE);
    do_load(32'h0001_0003, 3'd4, "t2 lbu", got);
    chk("t2 lbu lit", got, 32'h0000_00DE);
    do_load(32'h0001_0002, 3'd1, "t2 lh", got);
    chk("t2 lh lit", got, 32'hFFFF_DEAD);
    // 3: byte store into the held word
    do_store(32'h0001_0001, 3'd0, 32'h0000_0055, "t3 sb");
    do_load(32'h0001_0000, 3'd2, "t3 lw", got);
    chk("t3 lw lit", got, 32'hDEAD_55EF);
    // 4: misaligned store suppressed, flag set then cleared
    do_store(32'h0001_0002, 3'd2, 32'h1234_5678, "t4 sw mis");
    chk("t4 flag set", {31'd0, mis}, 32'd1);
    do_load(32'h0001_0000, 3'd2, "t4 lw", got);
    chk("t4 lw lit", got, 32'hDEAD_55EF);
    do_store(MMIO_B + 32'h8, 3'd2, 32'd0, "t4 clr");
    chk("t4 flag clr", {31'd0, mis}, 32'd0);
    do_load(MMIO_B + 32'h8, 3'd2, "t4 status", got);
    chk("t4 status lit", got, 32'd0);
    // 5: tick counter shadow and wrap
    do_store(MMIO_B + 32'h4, 3'd2, 32'd1, "t5 hi");
    do_store(MMIO_B + 32'h0, 3'd2, 32'hFFFF_FFFE, "t5 lo");
    do_load(MMIO_B + 32'h0, 3'd2, "t5 rd lo", got);
    chk("t5 lo lit", got, 32'hFFFF_FFFE);
    do_load(MMIO_B + 32'h4, 3'd2, "t5 rd hi", got);
    chk("t5 hi lit", got, 32'd1);
    do_load(MMIO_B + 32'h0, 3'd2, "t5 rd lo2", got);
    do_load(MMIO_B + 32'h4, 3'd2, "t5 rd hi2", got);
    chk("t5 hi wrap lit", got, 32'd2);
    // 6: reset during FILL
    addr = 32'h0001_0000; wd = 3'd2; we = 1'b0;
    @(negedge clk);
    chk("t6 hlt", {31'd0, hlt}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("t6 rst hlt", {31'd0, hlt}, 32'd0);
    chk("t6 rst data", dout, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; m_held_v = 1'b0; m_shadow = 32'd0;
    do_load(32'h0001_0000, 3'd2, "t6 lw", got);
    chk("t6 lw lit", got, 32'hDEAD_55EF);

    // randomized traffic against the model
    for (int i = 0; i < 16; i++) do_store(RAM_B + 32'(4 * i), 3'd2, $urandom, "init sw");
    last_a = RAM_B;
    for (int i = 0; i < 250; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: begin
          a = RAM_B + 32'($urandom_range(0, 63));
          do_load(a, ldw[$urandom_range(0, 7)], "rnd ld", got);
          last_a = a;
        end
        3: begin
          a = {last_a[31:2], 2'($urandom_range(0, 3))};
          do_load(a, ldw[$urandom_range(0, 7)], "rnd ld same", got);
        end
        4, 5: begin
          a = ($urandom_range(0, 1) == 0) ? {last_a[31:2], 2'($urandom_range(0, 3))}
                                          : RAM_B + 32'($urandom_range(0, 63));
          do_store(a, 3'($urandom_range(0, 2)), $urandom, "rnd st");
        end
        6: do_load(MMIO_B + 32'(4 * $urandom_range(0, 3)), 3'd2, "rnd mmio ld", got);
        7: begin
          a = MMIO_B + 32'(4 * $urandom_range(0, 3));
          do_store(a, 3'd2, $urandom, "rnd mmio st");
        end
        8: do_load(32'h0000_0100 + 32'($urandom_range(0, 15)), ldw[$urandom_range(0, 7)], "rnd unm ld", got);
        default: do_store(32'h0000_0100 + 32'($urandom_range(0, 15)), 3'($urandom_range(0, 2)),
                          $urandom, "rnd unm st");
      endcase
    end
    we = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
